// File: rtl/sseg_pkg.sv
// Shared constants and types for the six-digit seven-segment scan path.
package sseg_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 5;
  localparam int FRAME_W    = 30;
  localparam int SLOT_W     = 3;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'h0F;
  localparam logic [3:0]         MAX_BCD    = 4'd9;

  // Element NUM_DIGITS-1 holds slot 0 (leftmost), matching wr_data[29:25].
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_t;

  localparam frame_t BLANK_FRAME = {NUM_DIGITS{BLANK_CODE}};

  function automatic logic [DIGIT_W-1:0] slot_code(input frame_t f, input logic [SLOT_W-1:0] pos);
    return f[NUM_DIGITS-1-int'(pos)];
  endfunction
endpackage

// File: rtl/sseg_tick_gen.sv
// Slot prescaler: free-running 0..DIV-1 counter with a terminal-count tick.
module sseg_tick_gen #(
  parameter int DIV   = 8,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/sseg_scan.sv
// Six-digit scan controller: double-buffered frame, slot sequencing,
// PWM brightness and blanking of non-decimal codes.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic [2:0]         bright,
  output logic [DIGIT_W-1:0] digit,
  output logic [SLOT_W-1:0]  digit_pos,
  output logic               seg_en,
  output logic               frame_start,
  output logic               pending
);
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(DIV);

  if (DIV < 8 || (DIV % 8) != 0) begin : g_bad_div
    $error("sseg_scan: CLK_HZ/SCAN_HZ must be >= 8 and a multiple of 8");
  end

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [SLOT_W-1:0] pos_q, pos_d;
  frame_t            active_q, active_d, shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              fs_q, fs_d;
  logic              wrap, commit;
  logic [31:0]       on_lim;

  sseg_tick_gen #(.DIV(DIV), .CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt),
    .tick  (tick)
  );

  always_comb begin
    wrap     = tick && (pos_q == SLOT_W'(NUM_DIGITS - 1));
    commit   = wrap && pending_q;
    pos_d    = pos_q;
    if (tick) pos_d = wrap ? '0 : pos_q + 1'b1;
    // Commit reads the old shadow; a same-cycle write lands in shadow and stays pending.
    active_d  = commit ? shadow_q : active_q;
    shadow_d  = wr_en ? frame_t'(wr_data) : shadow_q;
    pending_d = wr_en ? 1'b1 : (commit ? 1'b0 : pending_q);
    fs_d      = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= '0;
      active_q  <= BLANK_FRAME;
      shadow_q  <= BLANK_FRAME;
      pending_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      fs_q      <= fs_d;
    end
  end

  // On-time is (bright+1) eighths of the slot; codes above 9 stay dark.
  always_comb begin
    on_lim = ({29'd0, bright} + 32'd1) * 32'(DIV / 8);
    digit  = slot_code(active_q, pos_q);
    seg_en = ({{(32-CNT_W){1'b0}}, cnt} < on_lim) && (digit[3:0] <= MAX_BCD);
  end

  assign digit_pos   = pos_q;
  assign frame_start = fs_q;
  assign pending     = pending_q;
endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan at DIV = 8 (48-cycle frame).
module tb_sseg_scan;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [29:0] wr_data;
  logic [2:0]  bright;
  logic [4:0]  digit;
  logic [2:0]  digit_pos;
  logic        seg_en, frame_start, pending;

  int n_run  = 0;
  int n_fail = 0;
  int k      = 0;

  sseg_scan #(.CLK_HZ(800), .SCAN_HZ(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .bright      (bright),
    .digit       (digit),
    .digit_pos   (digit_pos),
    .seg_en      (seg_en),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] br;
    int         slot;
    int         cnt;
    logic [4:0] dig;
    logic       en;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", name, act, exp, k, $time);
    end
  endtask

  // One clock edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic run_to_phase(input int slot, input int c);
    int guard = 0;
    while (!(((k / 8) % 6) == slot && (k % 8) == c)) begin
      step();
      guard++;
      if (guard > 100) begin
        chk("run_to_phase_timeout", 32'(guard), 32'd100);
        return;
      end
    end
  endtask

  task automatic write_frame(input logic [29:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  localparam logic [29:0] FR_A = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
  localparam logic [29:0] FR_B = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4};
  localparam logic [29:0] FR_C = {5'd8, 5'd8, 5'd8, 5'h1C, 5'h17, 5'd8};

  initial begin
    tbl[0]  = '{3'd1, 0, 0, 5'd8,  1'b1};
    tbl[1]  = '{3'd1, 0, 1, 5'd8,  1'b1};
    tbl[2]  = '{3'd1, 0, 2, 5'd8,  1'b0};
    tbl[3]  = '{3'd1, 0, 7, 5'd8,  1'b0};
    tbl[4]  = '{3'd1, 3, 0, 5'h1C, 1'b0};
    tbl[5]  = '{3'd1, 4, 0, 5'h17, 1'b1};
    tbl[6]  = '{3'd1, 4, 2, 5'h17, 1'b0};
    tbl[7]  = '{3'd7, 5, 7, 5'd8,  1'b1};
    tbl[8]  = '{3'd7, 0, 5, 5'd8,  1'b1};
    tbl[9]  = '{3'd7, 3, 7, 5'h1C, 1'b0};
    tbl[10] = '{3'd7, 4, 7, 5'h17, 1'b1};
    tbl[11] = '{3'd0, 5, 0, 5'd8,  1'b1};
    tbl[12] = '{3'd0, 5, 1, 5'd8,  1'b0};
    tbl[13] = '{3'd3, 0, 3, 5'd8,  1'b1};
    tbl[14] = '{3'd3, 0, 4, 5'd8,  1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; bright = 3'd7;
    repeat (3) @(negedge clk);
    chk("rst_digit",   32'(digit),       32'h0F);
    chk("rst_pos",     32'(digit_pos),   32'd0);
    chk("rst_seg_en",  32'(seg_en),      32'd0);
    chk("rst_fs",      32'(frame_start), 32'd0);
    chk("rst_pending", 32'(pending),     32'd0);
    rst_n = 1'b1; k = 0;

    // Blank scan: positions step every 8 cycles, frame_start every 48.
    for (int i = 0; i < 100; i++) begin
      step();
      chk("blank_pos",    32'(digit_pos),   32'((k / 8) % 6));
      chk("blank_fs",     32'(frame_start), 32'(k % 48 == 0));
      chk("blank_seg_en", 32'(seg_en),      32'd0);
    end

    // Commit lands exactly at the wrap.
    run_to_phase(2, 0);
    write_frame(FR_A);
    chk("wr_pending", 32'(pending), 32'd1);
    chk("wr_digit_hold", 32'(digit), 32'h0F);
    run_to_phase(5, 7);
    chk("pre_wrap_digit", 32'(digit), 32'h0F);
    chk("pre_wrap_pending", 32'(pending), 32'd1);
    step();
    chk("commit_pos", 32'(digit_pos), 32'd0);
    chk("commit_fs", 32'(frame_start), 32'd1);
    chk("commit_slot0", 32'(digit), 32'd1);
    chk("commit_pending", 32'(pending), 32'd0);
    chk("commit_seg_en", 32'(seg_en), 32'd1);
    run_to_phase(5, 0);
    chk("commit_slot5", 32'(digit), 32'd6);

    // Brightness and blanking table.
    run_to_phase(1, 0);
    write_frame(FR_C);
    run_to_phase(0, 0);
    chk("c_loaded", 32'(digit), 32'd8);
    for (int i = 0; i < 15; i++) begin
      bright = tbl[i].br;
      run_to_phase(tbl[i].slot, tbl[i].cnt);
      chk($sformatf("vec%0d_digit", i), 32'(digit), 32'(tbl[i].dig));
      chk($sformatf("vec%0d_seg_en", i), 32'(seg_en), 32'(tbl[i].en));
    end
    bright = 3'd7;

    // Write colliding with the commit tick.
    run_to_phase(1, 0);
    write_frame(FR_A);
    run_to_phase(5, 7);
    write_frame(FR_B);
    chk("coll_fs", 32'(frame_start), 32'd1);
    chk("coll_a_slot0", 32'(digit), 32'd1);
    chk("coll_pending", 32'(pending), 32'd1);
    run_to_phase(5, 0);
    chk("coll_a_slot5", 32'(digit), 32'd6);
    run_to_phase(0, 0);
    chk("coll_b_slot0", 32'(digit), 32'd9);
    chk("coll_b_pending", 32'(pending), 32'd0);
    run_to_phase(5, 0);
    chk("coll_b_slot5", 32'(digit), 32'd4);

    // Async reset between edges at slot 4 with a frame pending.
    run_to_phase(4, 3);
    write_frame(FR_C);
    chk("ar_pre_pending", 32'(pending), 32'd1);
    chk("ar_pre_pos", 32'(digit_pos), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pos",     32'(digit_pos),   32'd0);
    chk("ar_digit",   32'(digit),       32'h0F);
    chk("ar_seg_en",  32'(seg_en),      32'd0);
    chk("ar_pending", 32'(pending),     32'd0);
    chk("ar_fs",      32'(frame_start), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; k = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("ar_blank_digit", 32'(digit), 32'h0F);
      chk("ar_blank_seg_en", 32'(seg_en), 32'd0);
    end
    chk("ar_after_pending", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sseg_scan.md
Name: sseg_scan

Overview:
Time-multiplexing scan controller for the six-digit seven-segment display. It holds a six-digit frame and sequences the digit/position code pair into the existing combinational segment decoder, one digit slot per refresh period. It provides tear-free double-buffered frame updates, PWM brightness and blanking of non-decimal codes. It sits between the clock/time logic (writer) and the segment decoder/pins.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
SCAN_HZ, 1000, per-digit slot rate in Hz; DIV = CLK_HZ/SCAN_HZ cycles per slot, DIV >= 8 and DIV divisible by 8 (elaboration error otherwise)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  one-cycle strobe: load wr_data into shadow frame
wr_data  in  30  six 5-bit digit codes {dp,bcd[3:0]}; [29:25]=slot 0 (leftmost) ... [4:0]=slot 5
bright  in  3  brightness level 0..7
digit  out  5  code for current slot, to decoder digit input
digit_pos  out  3  current slot 0..5, to decoder digit_pos input
seg_en  out  1  1 = drive current slot; top level forces all position lines inactive (high) when 0
frame_start  out  1  one-cycle pulse on first cycle of slot 0
pending  out  1  shadow frame loaded, not yet committed

Behaviour:
- Single clock domain, asynchronous active-low reset; reset is clock independent and state is re-initialised when rst_n is asserted mid-scan.
- Reset values: prescaler count 0, digit_pos 0, active and shadow frames all slots 5'h0F (blank code), pending 0, frame_start 0.
- Consequence: after reset, digit = 5'h0F and seg_en = 0. The display stays dark until the first commit.
- Prescaler: cnt counts 0..DIV-1 and wraps. tick is asserted when cnt == DIV-1.
- On tick, digit_pos advances 0→1→…→5→0. Value 5 wraps to 0, and values 6/7 are never produced.
- Commit: on a tick where digit_pos == 5 (the wrap) and pending == 1:
  - active <= shadow
  - pending <= 0
  - the new frame is visible from the first cycle of slot 0
  - frames never change mid-scan
- Write: wr_en loads shadow <= wr_data and sets pending <= 1 on the next edge. A further write before commit overwrites the shadow, so last write wins.
- Simultaneous wr_en and commit in the same cycle:
  - active takes the old shadow
  - shadow takes the new wr_data
  - pending stays 1, so the new data commits at the next wrap
- digit = active slot[digit_pos], a combinational select from registers. digit_pos is the registered slot counter.
- seg_en = (cnt < (bright+1)*DIV/8) AND (digit[3:0] <= 9).
  - bright = 7 gives 100% on-time.
  - bright = 0 gives 1/8 on-time.
  - Codes 10..15 are always blanked, because the decoder holds stale segments for them.
- frame_start is registered: 1 exactly in the cycle where digit_pos has just become 0 (first cycle of slot 0), else 0. It does not fire after reset until the first wrap.
- pending output = pending register.
- Full frame period = 6*DIV cycles. Latency from wr_en to visible: 1 cycle to shadow, then up to 6*DIV cycles to the next wrap.
- bright may change at any time; it takes effect on the next cycle's compare. A mid-slot change may shorten or lengthen one on-period, which is accepted.

Decomposition:
- Shared package/include sseg_pkg:
  - NUM_DIGITS = 6
  - DIGIT_W = 5
  - FRAME_W = 30
  - BLANK_CODE = 5'h0F
  - MAX_BCD = 9
  - slot-index width 3
- One sub-module, sseg_tick_gen: the parameterised prescaler (DIV). Outputs cnt and tick, used for both the slot advance and the PWM compare.

Test Plan:
- Reset/blank (CLK_HZ=800, SCAN_HZ=100, DIV=8): release rst_n, run 100 cycles → seg_en == 0 throughout; digit_pos steps 0..5 every 8 cycles; frame_start pulses every 48 cycles.
- Commit at wrap: wr_en with wr_data = {5'd1,5'd2,5'd3,5'd4,5'd5,5'd6} while digit_pos == 2 → pending = 1; digit unchanged until the cycle digit_pos becomes 0; then digit = 1 at slot 0 and 6 at slot 5; pending = 0.
- Collision: wr_en with frame B on the exact wrap tick while frame A is pending → frame A displays this scan, pending stays 1, frame B displays next scan.
- Brightness: bright = 1, digits all 8 → seg_en high for cnt 0..1 of each 8-cycle slot; bright = 7 → seg_en constantly 1.
- Code blanking: slot 3 = 5'h1C (dp set, bcd 12) → seg_en = 0 for all of slot 3; slot 4 = 5'h17 → seg_en follows PWM with digit = 5'h17.
- Async reset mid-scan: assert rst_n low at digit_pos = 4 between clock edges → outputs return to reset values immediately, without a clock edge; pending cleared; the next display shows blank.
